// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// The response-stage struct carries data at the widest legal width; narrower configurations use its low bits.
package instr_mem_pkg;

    localparam int DW_NARROW       = 32;
    localparam int DW_WIDE         = 128;
    localparam int DW_MAX          = DW_WIDE;
    localparam int WORD_OFS_NARROW = 2;
    localparam int WORD_OFS_WIDE   = 4;

    localparam logic [DW_MAX-1:0] OOR_RDATA_DEFAULT = '0;

    typedef struct packed {
        logic              valid;
        logic              oor;
        logic [DW_MAX-1:0] data;
    } resp_stage_t;

    function automatic int word_ofs(input int data_w);
        return (data_w == DW_WIDE) ? WORD_OFS_WIDE : WORD_OFS_NARROW;
    endfunction

endpackage

// File: rtl/instr_mem_resp_pipe.sv
// LATENCY-deep response delay line; SRAM data is captured while its request sits in stage 0.
// Each stage only loads data behind a valid entry, so the output holds the last response between beats.
module instr_mem_resp_pipe
    import instr_mem_pkg::*;
#(
    parameter int                    LATENCY    = 1,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] OOR_RDATA  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_oor,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    resp_stage_t           r_stage [LATENCY];
    logic [DATA_WIDTH-1:0] w_cap;
    logic                  w_unused_bits;

    assign w_cap = r_stage[0].oor ? OOR_RDATA : i_mem_rdata;

    // Stage 0 takes the grant; stage 1 takes the SRAM word; later stages only shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0].valid <= i_valid;
            r_stage[0].oor   <= i_oor;
            if (r_stage[0].valid) begin
                r_stage[0].data <= DW_MAX'(w_cap);
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i].valid <= r_stage[i-1].valid;
                r_stage[i].oor   <= r_stage[i-1].oor;
                if (r_stage[i-1].valid) begin
                    r_stage[i].data <= (i == 1) ? DW_MAX'(w_cap) : r_stage[i-1].data;
                end
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_comb_out
            // Stage 0 data doubles as the hold register for the combinational output.
            assign o_rvalid = r_stage[0].valid;
            assign o_rdata  = r_stage[0].valid ? w_cap : r_stage[0].data[DATA_WIDTH-1:0];
        end else begin : g_reg_out
            assign o_rvalid = r_stage[LATENCY-1].valid;
            assign o_rdata  = r_stage[LATENCY-1].data[DATA_WIDTH-1:0];
        end
    endgenerate

    assign w_unused_bits = ^{r_stage[0].data, r_stage[LATENCY-1].data, r_stage[LATENCY-1].oor};

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch slave: grants requests, reads a synchronous SRAM and returns data in order
// after a fixed latency, with an outstanding cap and wait-state injection on the grant.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 14,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    LATENCY         = 1,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [DATA_WIDTH-1:0] OOR_RDATA       = OOR_RDATA_DEFAULT[DATA_WIDTH-1:0]
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  stall_gnt_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [2:0]            outstanding_o
);

    localparam int         WORD_OFS = word_ofs(DATA_WIDTH);
    localparam logic [2:0] MAX_OUT  = 3'(MAX_OUTSTANDING);

    logic                  w_oor;
    logic                  w_retire;
    logic                  w_gnt;
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_unused_addr;
    logic [2:0]            r_outstanding;

    assign w_oor         = |instr_addr_i[31:ADDR_WIDTH+2];
    assign w_word        = ADDR_WIDTH'(instr_addr_i[ADDR_WIDTH+1:WORD_OFS]);
    assign w_unused_addr = ^instr_addr_i[WORD_OFS-1:0];

    // A response leaving this cycle frees a slot, so a full responder can still grant.
    assign w_retire = instr_rvalid_o;
    assign w_gnt    = instr_req_i & ~stall_gnt_i & ~rst & ((r_outstanding < MAX_OUT) | w_retire);

    assign instr_gnt_o   = w_gnt;
    assign mem_en_o      = w_gnt & ~w_oor;
    assign mem_addr_o    = w_word;
    assign outstanding_o = r_outstanding;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_gnt, w_retire})
                2'b10:   r_outstanding <= r_outstanding + 3'd1;
                2'b01:   r_outstanding <= r_outstanding - 3'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    instr_mem_resp_pipe #(
        .LATENCY    (LATENCY),
        .DATA_WIDTH (DATA_WIDTH),
        .OOR_RDATA  (OOR_RDATA)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_gnt),
        .i_oor       (w_oor),
        .i_mem_rdata (mem_rdata_i),
        .o_rvalid    (instr_rvalid_o),
        .o_rdata     (instr_rdata_o)
    );

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: four configurations share one request stream, each with its own SRAM stub.
// inst0 L=1/M=2, inst1 L=2/M=2, inst2 L=3/M=1 (all 32-bit), inst3 L=3/M=3 at 128-bit.
module tb_instr_mem_responder;

    localparam int NI = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         stall;
    logic [31:0]  addr;
    logic         gnt   [NI];
    logic         men   [NI];
    logic         rv    [NI];
    logic [13:0]  maddr [NI];
    logic [2:0]   outs  [NI];
    logic [31:0]  rd32  [3];
    logic [31:0]  mrd32 [3];
    logic [127:0] rdw;
    logic [127:0] mrdw;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .LATENCY(1), .MAX_OUTSTANDING(2)) u_l1 (
        .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[0]),
        .instr_rvalid_o(rv[0]), .instr_rdata_o(rd32[0]), .stall_gnt_i(stall), .mem_en_o(men[0]),
        .mem_addr_o(maddr[0]), .mem_rdata_i(mrd32[0]), .outstanding_o(outs[0]));

    instr_mem_responder #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .LATENCY(2), .MAX_OUTSTANDING(2)) u_l2 (
        .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[1]),
        .instr_rvalid_o(rv[1]), .instr_rdata_o(rd32[1]), .stall_gnt_i(stall), .mem_en_o(men[1]),
        .mem_addr_o(maddr[1]), .mem_rdata_i(mrd32[1]), .outstanding_o(outs[1]));

    instr_mem_responder #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .LATENCY(3), .MAX_OUTSTANDING(1)) u_l3 (
        .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[2]),
        .instr_rvalid_o(rv[2]), .instr_rdata_o(rd32[2]), .stall_gnt_i(stall), .mem_en_o(men[2]),
        .mem_addr_o(maddr[2]), .mem_rdata_i(mrd32[2]), .outstanding_o(outs[2]));

    instr_mem_responder #(.ADDR_WIDTH(14), .DATA_WIDTH(128), .LATENCY(3), .MAX_OUTSTANDING(3)) u_w (
        .clk(clk), .rst(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt[3]),
        .instr_rvalid_o(rv[3]), .instr_rdata_o(rdw), .stall_gnt_i(stall), .mem_en_o(men[3]),
        .mem_addr_o(maddr[3]), .mem_rdata_i(mrdw), .outstanding_o(outs[3]));

    // SRAM contents: word 5 holds the test-plan instruction, others a per-address pattern.
    function automatic logic [31:0] sram32(input logic [13:0] w);
        if (w == 14'd5) return 32'h00A00093;
        return {w, 2'b01, ~w, 2'b10};
    endfunction

    function automatic logic [127:0] sram128(input logic [13:0] w);
        logic [31:0] b;
        b = sram32(w);
        return {b ^ 32'h3, b ^ 32'h2, b ^ 32'h1, b};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (men[k]) mrd32[k] <= sram32(maddr[k]);
        end
        if (men[3]) mrdw <= sram128(maddr[3]);
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int max_of(input int k);
        case (k)
            0, 1:    return 2;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [13:0] word_of(input int k, input logic [31:0] a);
        return (k == 3) ? {2'b00, a[15:4]} : a[15:2];
    endfunction

    function automatic logic [127:0] data_of(input int k, input logic [31:0] a);
        if (|a[31:16]) return '0;
        if (k == 3) return sram128(word_of(k, a));
        return {96'd0, sram32(word_of(k, a))};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; stall = 1'b0; addr = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; stall = 1'b0; addr = 32'h14;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                checks++;
                if ({gnt[k], men[k], rv[k], outs[k]} !== 6'b0) begin
                    errors++;
                    $display("FAIL reset_ctrl inst=%0d got gnt=%b en=%b rvalid=%b out=%0d, want all zero",
                             k, gnt[k], men[k], rv[k], outs[k]);
                end
            end
            checks++;
            if ({rd32[0], rd32[1], rd32[2], rdw} !== 224'd0) begin
                errors++;
                $display("FAIL reset_rdata got %h %h %h %h, want zero", rd32[0], rd32[1], rd32[2], rdw);
            end
            next_cycle();
        end
        req = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 1'b1; addr = 32'h14;
        @(negedge clk);
        checks++;
        if ({gnt[0], men[0], maddr[0], outs[0]} !== {1'b1, 1'b1, 14'd5, 3'd0}) begin
            errors++;
            $display("FAIL single_grant got gnt=%b en=%b addr=%0d out=%0d, want 1 1 5 0", gnt[0], men[0], maddr[0], outs[0]);
        end
        next_cycle();
        req = 1'b0; addr = $urandom;
        @(negedge clk);
        checks++;
        if ({rv[0], outs[0]} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL single_rvalid got rvalid=%b out=%0d, want 1 1", rv[0], outs[0]);
        end
        checks++;
        if (rd32[0] !== 32'h00A00093) begin
            errors++;
            $display("FAIL single_rdata got %h want 00a00093", rd32[0]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({rv[0], outs[0]} !== 4'b0) begin
            errors++;
            $display("FAIL single_idle got rvalid=%b out=%0d, want 0 0", rv[0], outs[0]);
        end
    endtask

    task automatic test_stream();
        int   peak;
        logic e_g, e_rv;
        peak = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req = (c < 4); addr = 32'(4 * c);
            @(negedge clk);
            if (int'(outs[1]) > peak) peak = int'(outs[1]);
            e_g  = (c < 4);
            e_rv = (c >= 2 && c < 6);
            checks++;
            if ({gnt[1], rv[1]} !== {e_g, e_rv}) begin
                errors++;
                $display("FAIL stream_hs cyc=%0d got gnt=%b rvalid=%b, want %b %b", c, gnt[1], rv[1], e_g, e_rv);
            end
            if (e_g) begin
                checks++;
                if (maddr[1] !== 14'(c)) begin
                    errors++;
                    $display("FAIL stream_addr cyc=%0d got %0d want %0d", c, maddr[1], c);
                end
            end
            if (e_rv) begin
                checks++;
                if (rd32[1] !== sram32(14'(c - 2))) begin
                    errors++;
                    $display("FAIL stream_rdata cyc=%0d got %h want %h", c, rd32[1], sram32(14'(c - 2)));
                end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (peak != 2 || outs[1] !== 3'd0) begin
            errors++;
            $display("FAIL stream_outstanding got peak=%0d final=%0d, want 2 0", peak, outs[1]);
        end
    endtask

    task automatic test_cap();
        logic       e_g, e_rv;
        logic [2:0] e_o;
        do_reset();
        req = 1'b1; addr = 32'h40;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e_g  = (c % 3 == 0);
            e_rv = (c >= 3 && c % 3 == 0);
            e_o  = (c == 0) ? 3'd0 : 3'd1;
            checks++;
            if ({gnt[2], rv[2], outs[2]} !== {e_g, e_rv, e_o}) begin
                errors++;
                $display("FAIL cap cyc=%0d got gnt=%b rvalid=%b out=%0d, want %b %b %0d",
                         c, gnt[2], rv[2], outs[2], e_g, e_rv, e_o);
            end
            if (e_rv) begin
                checks++;
                if (rd32[2] !== sram32(14'd16)) begin
                    errors++;
                    $display("FAIL cap_rdata cyc=%0d got %h want %h", c, rd32[2], sram32(14'd16));
                end
            end
            next_cycle();
        end
        req = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        req = 1'b1; addr = 32'h20;
        for (int c = 0; c < 8; c++) begin
            stall = (c != 3);
            @(negedge clk);
            checks++;
            if ({gnt[0], men[0], rv[0]} !== {c == 3, c == 3, c == 4}) begin
                errors++;
                $display("FAIL stall_l1 cyc=%0d got gnt=%b en=%b rvalid=%b", c, gnt[0], men[0], rv[0]);
            end
            checks++;
            if ({gnt[2], rv[2]} !== {c == 3, c == 6}) begin
                errors++;
                $display("FAIL stall_l3 cyc=%0d got gnt=%b rvalid=%b", c, gnt[2], rv[2]);
            end
            if (c == 3) begin
                checks++;
                if (maddr[0] !== 14'd8) begin
                    errors++;
                    $display("FAIL stall_addr got %0d want 8", maddr[0]);
                end
            end
            if (c == 4 || c == 6) begin
                checks++;
                if ((c == 4 ? rd32[0] : rd32[2]) !== sram32(14'd8)) begin
                    errors++;
                    $display("FAIL stall_rdata cyc=%0d got %h %h want %h", c, rd32[0], rd32[2], sram32(14'd8));
                end
            end
            next_cycle();
        end
        req = 1'b0; stall = 1'b0;
    endtask

    task automatic test_oor();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req  = (c < 2);
            addr = (c == 1) ? 32'h0001_0000 : 32'h14;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({gnt[0], men[0], gnt[3], men[3]} !== 4'b1010) begin
                    errors++;
                    $display("FAIL oor_access got gnt/en l1=%b%b w=%b%b, want 10 10", gnt[0], men[0], gnt[3], men[3]);
                end
            end
            checks++;
            if ({rv[0], rv[3]} !== {c == 1 || c == 2, c == 3 || c == 4}) begin
                errors++;
                $display("FAIL oor_rvalid cyc=%0d got l1=%b w=%b", c, rv[0], rv[3]);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (rd32[0] !== ((c == 1) ? 32'h00A00093 : 32'h0)) begin
                    errors++;
                    $display("FAIL oor_rdata_l1 cyc=%0d got %h", c, rd32[0]);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (rdw !== ((c == 3) ? sram128(14'd1) : 128'h0)) begin
                    errors++;
                    $display("FAIL oor_rdata_w cyc=%0d got %h", c, rdw);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rst  = (c == 2);
            req  = (c < 4);
            addr = (c == 3) ? 32'h50 : 32'(32'h30 + 4 * c);
            @(negedge clk);
            if (c < 2) begin
                checks++;
                if (gnt[3] !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_grant cyc=%0d got %b want 1", c, gnt[3]);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({gnt[3], outs[3]} !== {c == 3, 3'd0}) begin
                    errors++;
                    $display("FAIL rstmid_state cyc=%0d got gnt=%b out=%0d", c, gnt[3], outs[3]);
                end
            end
            checks++;
            if (rv[3] !== (c == 6)) begin
                errors++;
                $display("FAIL rstmid_rvalid cyc=%0d got %b want %b", c, rv[3], c == 6);
            end
            if (c == 6) begin
                checks++;
                if ({rdw, outs[3]} !== {sram128(14'd5), 3'd1}) begin
                    errors++;
                    $display("FAIL rstmid_fresh got rdata=%h out=%0d want %h 1", rdw, outs[3], sram128(14'd5));
                end
            end
            next_cycle();
        end
        req = 1'b0;
    endtask

    // Reference: each instance keeps a queue of (due cycle, data) for granted, unreturned requests.
    task automatic test_random();
        int           cnt  [NI];
        int           head [NI];
        int           due  [NI][8];
        logic [127:0] dat  [NI][8];
        logic         e_rv, e_g, e_en, oor;
        logic [127:0] e_rd, o_rd;
        int           slot;
        do_reset();
        for (int k = 0; k < NI; k++) begin
            cnt[k] = 0; head[k] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            req   = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 4) == 0);
            addr  = $urandom;
            if ($urandom_range(0, 7) != 0) addr[31:16] = '0;
            else addr[16 + $urandom_range(0, 15)] = 1'b1;
            oor = |addr[31:16];
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (rst) cnt[k] = 0;
                e_rv = !rst && cnt[k] > 0 && due[k][head[k]] == c;
                e_rd = e_rv ? dat[k][head[k]] : '0;
                e_g  = req && !stall && !rst && (cnt[k] < max_of(k) || e_rv);
                e_en = e_g && !oor;
                if (k == 3) o_rd = rdw;
                else o_rd = {96'd0, rd32[k]};
                checks++;
                if ({gnt[k], men[k], rv[k], outs[k]} !== {e_g, e_en, e_rv, 3'(cnt[k])}) begin
                    errors++;
                    $display("FAIL rand_ctrl inst=%0d cyc=%0d got gnt/en/rv=%b%b%b out=%0d want %b%b%b out=%0d",
                             k, c, gnt[k], men[k], rv[k], outs[k], e_g, e_en, e_rv, cnt[k]);
                end
                if (e_en) begin
                    checks++;
                    if (maddr[k] !== word_of(k, addr)) begin
                        errors++;
                        $display("FAIL rand_addr inst=%0d cyc=%0d got %h want %h", k, c, maddr[k], word_of(k, addr));
                    end
                end
                if (e_rv) begin
                    checks++;
                    if (o_rd !== e_rd) begin
                        errors++;
                        $display("FAIL rand_rdata inst=%0d cyc=%0d got %h want %h", k, c, o_rd, e_rd);
                    end
                    head[k] = (head[k] + 1) % 8;
                    cnt[k]--;
                end
                if (e_g) begin
                    slot = (head[k] + cnt[k]) % 8;
                    due[k][slot] = c + lat_of(k);
                    dat[k][slot] = data_of(k, addr);
                    cnt[k]++;
                end
            end
            next_cycle();
        end
        rst = 1'b0; req = 1'b0; stall = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; stall = 1'b0; addr = '0;
        test_reset();
        test_single();
        test_stream();
        test_cap();
        test_stall();
        test_oor();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
